iq_dispatch_ctrl: RTL and testbench

// - Instruction queue + dispatch scheduler between insfetch and decode. Buffers fetched

---
 rtl/iq_dispatch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_iq_dispatch_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_dispatch_ctrl.sv
// Instruction queue and in-order dispatch scheduler between fetch and decode.
// Optional same-cycle bypass of an empty queue is enabled by defining IQ_BYPASS_EN.
module iq_dispatch_ctrl #(
    parameter int unsigned IQ_W = 3
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    input  logic [31:0] if_ins,
    input  logic        if_pred_jmp,
    input  logic [31:0] if_pred_another,
    output logic        iq_full,
    input  logic        rs_full,
    input  logic        lsb_full,
    input  logic        rob_full,
    output logic        is_ins,
    output logic [31:0] ins_addr,
    output logic [31:0] ins,
    output logic        pred_jmp,
    output logic [31:0] pred_another
);

    localparam int unsigned DEPTH = 1 << IQ_W;
    localparam logic [IQ_W:0] FULL_CNT = (IQ_W + 1)'(DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] word;
        logic        pred_jmp;
        logic [31:0] pred_another;
    } iq_entry_t;

    // Target-unit gating: RS users and LSB users also need their unit; everything needs the ROB.
    function automatic logic unit_ready(input logic [6:0] op, input logic rs_f,
                                        input logic lsb_f, input logic rob_f);
        logic need_rs;
        logic need_lsb;
        need_rs  = (op == OP_JALR) || (op == OP_BRANCH) || (op == OP_IMM) || (op == OP_REG);
        need_lsb = (op == OP_LOAD) || (op == OP_STORE);
        return !rob_f && !(need_rs && rs_f) && !(need_lsb && lsb_f);
    endfunction

    logic [0:0]      state;
    logic [0:0]      state_next;
    logic [IQ_W-1:0] head;
    logic [IQ_W-1:0] tail;
    logic [IQ_W:0]   count;
    iq_entry_t       mem [DEPTH];

    iq_entry_t in_entry;
    iq_entry_t head_entry;
    logic      run_ok;
    logic      do_flush;
    logic      do_issue;
    logic      do_push;
    logic      do_bypass;

    assign iq_full = (count == FULL_CNT) || (state == ST_FLUSH);

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a flush lasts one cycle unless clear is held
    always_comb begin
        state_next = state;
        if (rdy_in) begin
            state_next = clear_in ? ST_FLUSH : ST_RUN;
        end
    end

    // Push/issue/flush decisions for this cycle
    always_comb begin
        in_entry   = '{addr: if_addr, word: if_ins, pred_jmp: if_pred_jmp,
                       pred_another: if_pred_another};
        head_entry = mem[head];
        run_ok     = rdy_in && !clear_in && (state == ST_RUN);
        do_flush   = rdy_in && (clear_in || (state == ST_FLUSH));
        do_issue   = run_ok && (count != '0) &&
                     unit_ready(head_entry.word[6:0], rs_full, lsb_full, rob_full);
`ifdef IQ_BYPASS_EN
        do_bypass  = run_ok && if_valid && (count == '0) &&
                     unit_ready(if_ins[6:0], rs_full, lsb_full, rob_full);
`else
        do_bypass  = 1'b0;
`endif
        do_push    = run_ok && if_valid && !iq_full && !do_bypass;
    end

    // Queue storage; not reset, validity is tracked by head/tail/count
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[tail] <= in_entry;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (do_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_issue) begin
                head <= head + IQ_W'(1);
            end
            if (do_push) begin
                tail <= tail + IQ_W'(1);
            end
            if (do_push && !do_issue) begin
                count <= count + (IQ_W + 1)'(1);
            end else if (do_issue && !do_push) begin
                count <= count - (IQ_W + 1)'(1);
            end
        end
    end

    // Decode-side output registers; data holds when nothing issues, all held while !rdy_in
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            is_ins       <= 1'b0;
            ins_addr     <= '0;
            ins          <= '0;
            pred_jmp     <= 1'b0;
            pred_another <= '0;
        end else if (rdy_in) begin
            is_ins <= do_issue || do_bypass;
            if (do_bypass) begin
                ins_addr     <= in_entry.addr;
                ins          <= in_entry.word;
                pred_jmp     <= in_entry.pred_jmp;
                pred_another <= in_entry.pred_another;
            end else if (do_issue) begin
                ins_addr     <= head_entry.addr;
                ins          <= head_entry.word;
                pred_jmp     <= head_entry.pred_jmp;
                pred_another <= head_entry.pred_another;
            end
        end
    end

endmodule

// File: tb/tb_iq_dispatch_ctrl.sv
// Bench for iq_dispatch_ctrl: directed scenarios then random traffic against a queue model.
module tb_iq_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, rdy, clear, if_valid, if_pred_jmp;
    logic [31:0] if_addr, if_ins, if_pred_another;
    logic        rs_full, lsb_full, rob_full;
    logic        iq_full, is_ins, pred_jmp;
    logic [31:0] ins_addr, ins, pred_another;

    always #5 clk = ~clk;

    iq_dispatch_ctrl #(.IQ_W(3)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .clear_in(clear),
        .if_valid(if_valid), .if_addr(if_addr), .if_ins(if_ins),
        .if_pred_jmp(if_pred_jmp), .if_pred_another(if_pred_another),
        .iq_full(iq_full), .rs_full(rs_full), .lsb_full(lsb_full), .rob_full(rob_full),
        .is_ins(is_ins), .ins_addr(ins_addr), .ins(ins), .pred_jmp(pred_jmp),
        .pred_another(pred_another)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] i;
        logic        pj;
        logic [31:0] pa;
    } ent_t;

    ent_t q[$];
    ent_t m_out;
    logic m_is;
    logic m_flush;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [6:0] ops [10] = '{7'h13, 7'h33, 7'h63, 7'h67, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h73};

    function automatic bit unit_ok(input logic [6:0] op);
        bit rs_user  = (op == 7'h67) || (op == 7'h63) || (op == 7'h13) || (op == 7'h33);
        bit lsb_user = (op == 7'h03) || (op == 7'h23);
        if (rob_full) return 0;
        if (rs_user && rs_full) return 0;
        if (lsb_user && lsb_full) return 0;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".is_ins"}, 32'(is_ins), 32'(m_is));
        chk({tag, ".iq_full"}, 32'(iq_full), 32'((q.size() == 8) || m_flush));
        chk({tag, ".ins_addr"}, ins_addr, m_out.a);
        chk({tag, ".ins"}, ins, m_out.i);
        chk({tag, ".pred_jmp"}, 32'(pred_jmp), 32'(m_out.pj));
        chk({tag, ".pred_another"}, pred_another, m_out.pa);
    endtask

    task automatic model_reset();
        q.delete();
        m_flush = 1'b0;
        m_is    = 1'b0;
        m_out   = '{32'h0, 32'h0, 1'b0, 32'h0};
    endtask

    // One clock of the reference queue, from the current inputs
    task automatic model_step();
        ent_t inc;
        bit   was_full;
        inc = '{if_addr, if_ins, if_pred_jmp, if_pred_another};
        if (!rdy) return;
        if (clear) begin
            q.delete();
            m_flush = 1'b1;
            m_is    = 1'b0;
            return;
        end
        if (m_flush) begin
            m_flush = 1'b0;
            m_is    = 1'b0;
            return;
        end
        was_full = (q.size() == 8);
`ifdef IQ_BYPASS_EN
        if (q.size() == 0 && if_valid && unit_ok(if_ins[6:0])) begin
            m_out = inc;
            m_is  = 1'b1;
            return;
        end
`endif
        if (q.size() > 0 && unit_ok(q[0].i[6:0])) begin
            m_out = q.pop_front();
            m_is  = 1'b1;
        end else begin
            m_is = 1'b0;
        end
        if (if_valid && !was_full) q.push_back(inc);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [6:0] op);
        if_valid        = v;
        if_addr         = pc;
        if_ins          = {25'($urandom), op};
        if_pred_jmp     = 1'($urandom);
        if_pred_another = $urandom;
    endtask

    initial begin
        int          issued;
        logic [31:0] last_pc;
        rst_n = 1'b0; rdy = 1'b1; clear = 1'b0;
        rs_full = 1'b0; lsb_full = 1'b0; rob_full = 1'b0;
        drive(1'b0, 32'h0, 7'h13);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Fill with ALU ops behind a full RS; the ninth push is dropped
        rs_full = 1'b1;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 32'h1000 + 32'(4 * k), 7'h13);
            tick("fill8");
        end
        chk("fill8.full", 32'(iq_full), 32'd1);
        drive(1'b0, 32'h0, 7'h13);
        rs_full = 1'b0;
        issued = 0;
        for (int k = 0; k < 10; k++) begin
            tick("drain8");
            if (is_ins) issued++;
        end
        chk("drain8.count", 32'(issued), 32'd8);

        // Store at head blocked by LSB also blocks a younger addi
        lsb_full = 1'b1;
        drive(1'b1, 32'h2000, 7'h23); tick("sw_push");
        drive(1'b1, 32'h2004, 7'h13); tick("addi_push");
        drive(1'b0, 32'h0, 7'h13);
        repeat (3) tick("lsb_block");
        chk("lsb_block.is_ins", 32'(is_ins), 32'd0);
        lsb_full = 1'b0;
        tick("sw_issue");
        chk("sw_issue.addr", ins_addr, 32'h2000);
        tick("addi_issue");
        chk("addi_issue.addr", ins_addr, 32'h2004);
        tick("lsb_idle");

        // Flush with five queued and fetch still valid
        rs_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h3000 + 32'(4 * k), 7'h33);
            tick("pre_flush");
        end
        clear = 1'b1; tick("clear");
        chk("clear.iq_full", 32'(iq_full), 32'd1);
        clear = 1'b0; rs_full = 1'b0;
        drive(1'b1, 32'h0ff0, 7'h13); tick("flush_cycle");
        chk("flush_cycle.iq_full", 32'(iq_full), 32'd0);
        drive(1'b1, 32'h0100, 7'h13); tick("post_flush_push");
        drive(1'b0, 32'h0, 7'h13); tick("post_flush_issue");
        chk("post_flush.addr", ins_addr, 32'h0100);
        tick("post_flush_idle");

        // Hold at 7 with simultaneous push and issue while the tail wraps
        rs_full = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 32'h4000 + 32'(4 * k), 7'h13);
            tick("fill7");
        end
        rs_full = 1'b0;
        last_pc = 32'h3ffc;
        for (int k = 7; k < 27; k++) begin
            drive(1'b1, 32'h4000 + 32'(4 * k), 7'h13);
            tick("steady7");
            chk("steady7.order", ins_addr, last_pc + 32'd4);
            chk("steady7.not_full", 32'(iq_full), 32'd0);
            last_pc = ins_addr;
        end
        drive(1'b0, 32'h0, 7'h13);
        for (int k = 0; k < 7; k++) begin
            tick("drain7");
            chk("drain7.order", ins_addr, last_pc + 32'd4);
            last_pc = ins_addr;
        end
        tick("drain7_idle");

        // Freeze under rdy low while fetch and units would allow progress
        rs_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h5000 + 32'(4 * k), 7'h13);
            tick("pre_freeze");
        end
        rs_full = 1'b0;
        tick("freeze_issue_one");
        rdy = 1'b0;
        drive(1'b1, 32'h6000, 7'h13);
        clear = 1'b1;
        repeat (3) tick("frozen");
        chk("frozen.is_ins", 32'(is_ins), 32'd1);
        clear = 1'b0; rdy = 1'b1;
        drive(1'b0, 32'h0, 7'h13);
        tick("thaw");

        // Async reset in the middle of a cycle
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("async_rst.is_ins", 32'(is_ins), 32'd0);
        chk("async_rst.iq_full", 32'(iq_full), 32'd0);
        rst_n = 1'b1;
        tick("after_rst");

        // Empty queue, lui: visible right after the push edge only with bypass
        drive(1'b1, 32'h0200, 7'h37); tick("lui_push");
`ifdef IQ_BYPASS_EN
        chk("lui_push.is_ins", 32'(is_ins), 32'd1);
        chk("lui_push.addr", ins_addr, 32'h0200);
`else
        chk("lui_push.is_ins", 32'(is_ins), 32'd0);
`endif
        drive(1'b0, 32'h0, 7'h13); tick("lui_next");
`ifndef IQ_BYPASS_EN
        chk("lui_next.is_ins", 32'(is_ins), 32'd1);
        chk("lui_next.addr", ins_addr, 32'h0200);
`endif

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            rdy      = ($urandom_range(0, 9) != 0);
            clear    = ($urandom_range(0, 39) == 0);
            rs_full  = ($urandom_range(0, 2) == 0);
            lsb_full = ($urandom_range(0, 2) == 0);
            rob_full = ($urandom_range(0, 4) == 0);
            drive(1'($urandom), $urandom, ops[$urandom_range(0, 9)]);
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
